// File: rtl/gate_sweep_pkg.sv
// rtl/gate_sweep_pkg.sv - shared types and constants for the gate sweep checker
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NUM_VEC = 8;
  localparam int VEC_W   = 3;
  localparam logic [NUM_VEC-1:0] NOR3_TABLE = 8'h01;

  // An unknown ZN never equals the expected bit, so X/Z reads as a mismatch.
  function automatic logic vec_mismatch(input logic [NUM_VEC-1:0] tbl,
                                        input logic [VEC_W-1:0]   idx,
                                        input logic               zn);
    return (zn !== tbl[idx]);
  endfunction

endpackage

// File: rtl/gate_sweep_timer.sv
// rtl/gate_sweep_timer.sv - settle counter; tc_o marks the edge that ends a hold window
module gate_sweep_timer
  import gate_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - sweeps 3-input vectors into a gate and checks ZN
// Optional first-fail capture enabled by GATE_SWEEP_FIRST_FAIL_EN.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int unsigned        SETTLE_CYCLES = 10,
  parameter logic [NUM_VEC-1:0] EXP_TABLE     = NOR3_TABLE
) (
  input  logic               CK,
  input  logic               RN,
  input  logic               start,
  output logic               A1,
  output logic               A2,
  output logic               A3,
  input  logic               ZN,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_VEC-1:0] fail_map
`ifdef GATE_SWEEP_FIRST_FAIL_EN
  ,
  output logic               first_fail_valid,
  output logic [VEC_W-1:0]   first_fail_vec
`endif
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("gate_sweep_checker: SETTLE_CYCLES must be in 1..255");
  end

  state_e             state_q;
  logic [VEC_W-1:0]   vec_q;
  logic [VEC_W-1:0]   a_q;
  logic               busy_q, done_q, pass_q;
  logic [NUM_VEC-1:0] fail_map_q, fail_map_d;
  logic               accept, tc, miss;

  assign accept = (state_q != RUN) && start;
  assign miss   = vec_mismatch(EXP_TABLE, vec_q, ZN);

  always_comb begin
    fail_map_d = fail_map_q;
    if (tc && miss) begin
      fail_map_d[vec_q] = 1'b1;
    end
  end

  gate_sweep_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk_i (CK),
    .rst_ni(RN),
    .load_i(accept),
    .en_i  (state_q == RUN),
    .tc_o  (tc)
  );

`ifdef GATE_SWEEP_FIRST_FAIL_EN
  logic             ff_valid_q;
  logic [VEC_W-1:0] ff_vec_q;
`endif

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      a_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_map_q <= '0;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
      ff_valid_q <= 1'b0;
      ff_vec_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= RUN;
            vec_q      <= '0;
            a_q        <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_map_q <= '0;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
            ff_valid_q <= 1'b0;
            ff_vec_q   <= '0;
`endif
          end
        end
        RUN: begin
          if (tc) begin
            fail_map_q <= fail_map_d;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
            if (miss && !ff_valid_q) begin
              ff_valid_q <= 1'b1;
              ff_vec_q   <= vec_q;
            end
`endif
            // The last vector's sample edge also finalises the verdict.
            if (vec_q == VEC_W'(NUM_VEC - 1)) begin
              state_q <= DONE;
              a_q     <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (fail_map_d == '0);
            end else begin
              vec_q <= vec_q + 1'b1;
              a_q   <= vec_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          a_q     <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign {A1, A2, A3} = a_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail_map     = fail_map_q;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
  assign first_fail_valid = ff_valid_q;
  assign first_fail_vec   = ff_vec_q;
`endif

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb/tb_gate_sweep_checker.sv - directed and random sweeps against a truth-table model
module tb_gate_sweep_checker;

  logic       ck = 1'b0;
  logic       rn = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] tt_a = 8'h01, tt_b = 8'h01;
  logic       a1_a, a2_a, a3_a, zn_a, busy_a, done_a, pass_a;
  logic       a1_b, a2_b, a3_b, zn_b, busy_b, done_b, pass_b;
  logic [7:0] fm_a, fm_b;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
  logic       ffv_a, ffv_b;
  logic [2:0] ffn_a, ffn_b;
`endif

  int errors = 0;
  int checks = 0;

  always #5 ck = ~ck;

  // Gate under test: arbitrary truth table, A1 is the index MSB.
  assign zn_a = tt_a[{a1_a, a2_a, a3_a}];
  assign zn_b = tt_b[{a1_b, a2_b, a3_b}];

  gate_sweep_checker dut_a (
    .CK(ck), .RN(rn), .start(start_a),
    .A1(a1_a), .A2(a2_a), .A3(a3_a), .ZN(zn_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_map(fm_a)
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    , .first_fail_valid(ffv_a), .first_fail_vec(ffn_a)
`endif
  );

  gate_sweep_checker #(.SETTLE_CYCLES(1)) dut_b (
    .CK(ck), .RN(rn), .start(start_b),
    .A1(a1_b), .A2(a2_b), .A3(a3_b), .ZN(zn_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail_map(fm_b)
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    , .first_fail_valid(ffv_b), .first_fail_vec(ffn_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: vector i fails when the gate's output differs from the NOR3 expectation.
  function automatic logic [7:0] model_fail(input logic [7:0] tt);
    logic [7:0] m = '0;
    for (int i = 0; i < 8; i++) begin
      logic want = (i == 0);
      if (tt[i] != want) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic int model_first(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic sweep_a(input logic [7:0] tt, input int repulse_at);
    logic [7:0] exp_fm;
    tt_a   = tt;
    exp_fm = model_fail(tt);
    @(posedge ck); #1 start_a = 1'b1;
    @(posedge ck); #1 start_a = 1'b0;
    check("start_busy", busy_a, 1);
    check("start_done_clr", done_a, 0);
    check("start_fm_clr", fm_a, 0);
    for (int c = 1; c < 80; c++) begin
      @(posedge ck); #1;
      start_a = (c == repulse_at);
    end
    check("pre_done_low", {busy_a, done_a}, 2'b10);
    @(posedge ck); #1 start_a = 1'b0;
    check("done_at_80", {busy_a, done_a}, 2'b01);
    check("done_vec_zero", {a1_a, a2_a, a3_a}, 0);
    check("fail_map", fm_a, exp_fm);
    check("pass", pass_a, exp_fm == 0);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    check("ff_valid", ffv_a, exp_fm != 0);
    check("ff_vec", ffn_a, model_first(exp_fm));
`endif
    repeat (5) @(posedge ck);
    #1;
    check("done_hold", {done_a, pass_a, fm_a}, {1'b1, exp_fm == 0, exp_fm});
  endtask

  initial begin
    logic [7:0] rtt;
    #2 rn = 1'b0;
    #1;
    check("rst_a_outs", {a1_a, a2_a, a3_a, busy_a, done_a, pass_a, fm_a}, 0);
    check("rst_b_outs", {a1_b, a2_b, a3_b, busy_b, done_b, pass_b, fm_b}, 0);
    @(posedge ck); @(posedge ck); #1 rn = 1'b1;

    // One-cycle settle: vectors step every cycle.
    @(posedge ck); #1 start_b = 1'b1;
    @(posedge ck); #1 start_b = 1'b0;
    check("b_vec0", {busy_b, a1_b, a2_b, a3_b}, 4'b1000);
    for (int k = 1; k < 8; k++) begin
      @(posedge ck); #1;
      check("b_vec_step", {busy_b, done_b, a1_b, a2_b, a3_b}, {2'b10, 3'(k)});
    end
    @(posedge ck); #1;
    check("b_done_8", {busy_b, done_b, pass_b, fm_b}, {3'b011, 8'h00});

    sweep_a(8'h01, 0);   // NOR3
    sweep_a(8'h7F, 0);   // NAND3
    sweep_a(8'h00, 0);   // stuck at 0
    sweep_a(8'h01, 25);  // restart attempt mid-run must be ignored

    // Reset in the middle of a sweep.
    tt_a = 8'h01;
    @(posedge ck); #1 start_a = 1'b1;
    @(posedge ck); #1 start_a = 1'b0;
    repeat (37) @(posedge ck);
    #2 rn = 1'b0;
    #1;
    check("midrun_rst", {a1_a, a2_a, a3_a, busy_a, done_a, pass_a, fm_a}, 0);
    @(posedge ck); #1;
    check("rst_held", {busy_a, done_a}, 0);
    rn = 1'b1;
    sweep_a(8'h01, 0);

    for (int r = 0; r < 4; r++) begin
      rtt = 8'($urandom);
      sweep_a(rtt, (r == 1) ? int'($urandom_range(1, 78)) : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
